// File: rtl/fb_scanner_if.sv
// Bundles the scanner's memory-read port and its column-byte stream port.
// master = scanner side, slave = arbiter/link-driver side.
interface fb_scanner_if;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_req, mem_addr, out_data, out_valid,
    input  mem_gnt, mem_rdata, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_data, out_valid,
    output mem_gnt, mem_rdata, out_ready
  );
endinterface

// File: rtl/fb_scanner.sv
// Scans the 64x32 framebuffer into SSD1306 page/column bytes, 8 rows per block.
// Define FB_SCANNER_FLIP_EN for a display mounted rotated by 180 degrees.
//
// state | meaning
// IDLE  | waiting for start (a start coinciding with frame_done is dropped)
// REQ   | read request for block row `row` held until granted
// CAP   | capture read data into block[row]
// EMIT  | stream the 8 column bytes of the captured block
module fb_scanner #(
  parameter logic [11:0] FB_BASE = 12'h100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  fb_scanner_if.master bus,
  output logic        o_busy,
  output logic        o_frame_done
);

`ifdef FB_SCANNER_FLIP_EN
  localparam logic       FLIP       = 1'b1;
  localparam logic [1:0] PAGE_FIRST = 2'd3;
  localparam logic [1:0] PAGE_LAST  = 2'd0;
  localparam logic [2:0] XB_FIRST   = 3'd7;
  localparam logic [2:0] XB_LAST    = 3'd0;
`else
  localparam logic       FLIP       = 1'b0;
  localparam logic [1:0] PAGE_FIRST = 2'd0;
  localparam logic [1:0] PAGE_LAST  = 2'd3;
  localparam logic [2:0] XB_FIRST   = 3'd0;
  localparam logic [2:0] XB_LAST    = 3'd7;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP, S_EMIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_page, w_page_nxt;
  logic [2:0]      r_xb, w_xb_nxt;
  logic [2:0]      r_row, w_row_nxt;
  logic [2:0]      r_col, w_col_nxt;
  logic [7:0][7:0] r_blk, w_blk_nxt;
  logic [7:0]      r_out_data, w_out_data_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic            r_mem_req, w_mem_req_nxt;
  logic [11:0]     r_mem_addr, w_mem_addr_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [1:0]      w_page_step;
  logic [2:0]      w_xb_step;

  // Column byte for pixel column `col` of the block; flipped mounting reverses
  // both the column order inside the byte and the row-to-bit mapping.
  function automatic logic [7:0] col_byte(input logic [7:0][7:0] blk,
                                          input logic [2:0] col);
    logic [7:0] v;
    logic [2:0] pbit;
    pbit = FLIP ? col : 3'd7 - col;
    for (int k = 0; k < 8; k++) begin
      v[k] = FLIP ? blk[7-k][pbit] : blk[k][pbit];
    end
    return v;
  endfunction

  assign w_page_step = FLIP ? r_page - 2'd1 : r_page + 2'd1;
  assign w_xb_step   = FLIP ? r_xb - 3'd1 : r_xb + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_xb_nxt    = r_xb;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_blk_nxt   = r_blk;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start && !r_done) begin
          w_state_nxt = S_REQ;
          w_page_nxt  = PAGE_FIRST;
          w_xb_nxt    = XB_FIRST;
          w_row_nxt   = 3'd0;
          w_col_nxt   = 3'd0;
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          w_state_nxt = S_CAP;
        end
      end
      S_CAP: begin
        w_blk_nxt[r_row] = bus.mem_rdata;
        if (r_row == 3'd7) begin
          w_state_nxt = S_EMIT;
          w_col_nxt   = 3'd0;
        end else begin
          w_state_nxt = S_REQ;
          w_row_nxt   = r_row + 3'd1;
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (r_col != 3'd7) begin
            w_col_nxt = r_col + 3'd1;
          end else if (r_xb != XB_LAST) begin
            w_state_nxt = S_REQ;
            w_xb_nxt    = w_xb_step;
            w_row_nxt   = 3'd0;
          end else if (r_page != PAGE_LAST) begin
            w_state_nxt = S_REQ;
            w_page_nxt  = w_page_step;
            w_xb_nxt    = XB_FIRST;
            w_row_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state presents, so they
    // stay put for as long as the state and counters do (REQ stall, EMIT stall).
    w_mem_req_nxt   = (w_state_nxt == S_REQ);
    w_mem_addr_nxt  = w_mem_req_nxt ?
                      FB_BASE + {4'b0000, w_page_nxt, w_row_nxt, w_xb_nxt} : 12'h000;
    w_out_valid_nxt = (w_state_nxt == S_EMIT);
    w_out_data_nxt  = w_out_valid_nxt ? col_byte(w_blk_nxt, w_col_nxt) : 8'h00;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_page      <= 2'd0;
      r_xb        <= 3'd0;
      r_row       <= 3'd0;
      r_col       <= 3'd0;
      r_blk       <= '0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 12'h000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_page      <= w_page_nxt;
      r_xb        <= w_xb_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_blk       <= w_blk_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_done;

endmodule

// File: tb/tb_fb_scanner.sv
// Directed frames plus randomized framebuffer/handshakes for fb_scanner,
// checked against a pixel-level model of the expected byte stream.
module tb_fb_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic busy;
  logic frame_done;

  fb_scanner_if bus();

  fb_scanner #(.FB_BASE(12'h100)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .bus          (bus.master),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  logic [7:0]  fb [256];
  int          checks = 0;
  int          errors = 0;
  bit          gnt_mode = 0;
  bit          gnt_hold = 0;
  bit          rdy_mode = 0;
  bit          rdy_hold = 0;
  logic [7:0]  rx_q [$];
  int          addr_seen [256];
  int          addr_bad = 0;
  int          done_cnt = 0;
  bit          g_pend = 0;
  logic [11:0] g_addr = 12'h000;

  // Arbiter/memory: grants seen before an edge return data right after it.
  initial begin
    bus.mem_gnt   = 1'b1;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_gnt && rst_n) begin
        g_pend = 1'b1;
        g_addr = bus.mem_addr;
        if (bus.mem_addr >= 12'h100 && bus.mem_addr <= 12'h1FF)
          addr_seen[bus.mem_addr[7:0]]++;
        else
          addr_bad++;
      end
      @(posedge clk);
      #1;
      if (g_pend) begin
        bus.mem_rdata = fb[g_addr[7:0]];
        g_pend = 1'b0;
      end else begin
        bus.mem_rdata = 8'($urandom);
      end
      bus.mem_gnt = gnt_hold ? 1'b0 : (gnt_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Link driver: collects transferred bytes and counts frame_done pulses.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && rst_n) rx_q.push_back(bus.out_data);
      if (frame_done) done_cnt++;
      @(posedge clk);
      #1;
      bus.out_ready = rdy_hold ? 1'b0 : (rdy_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  function automatic logic [7:0] unflip_byte(int i);
    int page = i / 64;
    int x = i % 64;
    logic [7:0] v;
    logic [7:0] src;
    for (int k = 0; k < 8; k++) begin
      src = fb[(page * 8 + k) * 8 + x / 8];
      v[k] = src[7 - (x % 8)];
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_byte(int i);
`ifdef FB_SCANNER_FLIP_EN
    logic [7:0] r;
    logic [7:0] v;
    r = unflip_byte(255 - i);
    for (int k = 0; k < 8; k++) v[k] = r[7 - k];
    return v;
`else
    return unflip_byte(i);
`endif
  endfunction

  function automatic logic [7:0] rx_at(int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fb_clear();
    for (int a = 0; a < 256; a++) fb[a] = 8'h00;
  endtask

  task automatic start_frame(input string tag);
    rx_q.delete();
    for (int a = 0; a < 256; a++) addr_seen[a] = 0;
    addr_bad = 0;
    done_cnt = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    int cov_bad = 0;
    int byte_err = 0;
    while (!frame_done && n < 20000) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 20000), 32'd1);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    start = 1'b1;                    // start coinciding with frame_done
    @(posedge clk); #2 start = 1'b0;
    check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
    check({tag, "_start_at_done"}, {30'd0, busy, bus.mem_req}, 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_count"}, 32'(rx_q.size()), 32'd256);
    for (int i = 0; i < 256; i++) begin
      if (rx_at(i) !== exp_byte(i)) begin
        byte_err++;
        check($sformatf("%s_b%0d", tag, i), 32'(rx_at(i)), 32'(exp_byte(i)));
      end
    end
    check({tag, "_bytes_bad"}, 32'(byte_err), 32'd0);
    for (int a = 0; a < 256; a++) if (addr_seen[a] != 1) cov_bad++;
    check({tag, "_addr_cov"}, 32'(cov_bad), 32'd0);
    check({tag, "_addr_range"}, 32'(addr_bad), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0]  d0;
    logic [11:0] a0;
    rst_n = 1'b0;
    start = 1'b0;
    fb_clear();
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Zero framebuffer, free-flowing handshakes.
    start_frame("zero");
    finish_frame("zero");

    fb[8'h00] = 8'h80;
    start_frame("tl");
    finish_frame("tl");
`ifndef FB_SCANNER_FLIP_EN
    check("tl_byte0", 32'(rx_at(0)), 32'h01);
`endif

    fb_clear();
    fb[8'hFF] = 8'h01;
    start_frame("br");
    finish_frame("br");
`ifdef FB_SCANNER_FLIP_EN
    check("br_byte0", 32'(rx_at(0)), 32'h01);
`else
    check("br_byte255", 32'(rx_at(255)), 32'h80);
`endif

    fb_clear();
    fb[8'h08] = 8'hFF;
    start_frame("row1");
    finish_frame("row1");

    // Glyph "1" in rows 7..11 of byte column 0.
    fb_clear();
    fb[8'h38] = 8'h20;
    fb[8'h40] = 8'h60;
    fb[8'h48] = 8'h20;
    fb[8'h50] = 8'h20;
    fb[8'h58] = 8'hE0;
    start_frame("glyph");
    finish_frame("glyph");
`ifndef FB_SCANNER_FLIP_EN
    check("glyph_p0c2", 32'(rx_at(2)), 32'h80);
    check("glyph_p1c0", 32'(rx_at(64)), 32'h08);
    check("glyph_p1c1", 32'(rx_at(65)), 32'h09);
    check("glyph_p1c2", 32'(rx_at(66)), 32'h0F);
    check("glyph_p1c3", 32'(rx_at(67)), 32'h00);
`endif

    // Random image with random grant/ready, stalls and a stray start.
    for (int a = 0; a < 256; a++) fb[a] = 8'($urandom);
    gnt_mode = 1'b1;
    rdy_mode = 1'b1;
    start_frame("rand");
    repeat (10) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    check("rand_busy_hold", 32'(busy), 32'd1);

    rdy_hold = 1'b1;
    @(posedge clk); #2;
    n = 0;
    while (!bus.out_valid && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
    d0 = bus.out_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp_data_hold", 32'(bus.out_data), 32'(d0));
    end
    rdy_hold = 1'b0;

    gnt_hold = 1'b1;
    @(posedge clk); #2;
    n = 0;
    while (!bus.mem_req && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("gs_req_seen", 32'(bus.mem_req), 32'd1);
    a0 = bus.mem_addr;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      check("gs_req_hold", 32'(bus.mem_req), 32'd1);
      check("gs_addr_hold", 32'(bus.mem_addr), 32'(a0));
      check("gs_no_emit", 32'(bus.out_valid), 32'd0);
    end
    gnt_hold = 1'b0;
    finish_frame("rand");

    // Reset in the middle of EMIT, then a fresh frame.
    for (int a = 0; a < 256; a++) fb[a] = 8'($urandom);
    start_frame("rst");
    n = 0;
    while (!bus.out_valid && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("rst_emit_seen", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    start_frame("after_rst");
    finish_frame("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_scanner.md
Name: fb_scanner

Overview:
- Reads the 64x32 monochrome framebuffer that the CPU writes at 0x100-0x1FF.
- Transposes it into SSD1306-style page/column bytes and streams them out over a valid/ready interface.
- Sits between the shared memory arbiter (as a read-only requester) and the display link driver.
- A full frame is 256 bytes: 4 pages x 64 columns.

Parameters:
- FB_BASE, 12'h100: framebuffer base address. Row r, byte column xb is at FB_BASE + r*8 + xb. MSB is the leftmost pixel.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a frame scan (e.g. the 60 Hz tick)
- mem_req  out  1  read request, held with mem_addr until granted
- mem_addr  out  12  read address
- mem_gnt  in  1  arbiter accepts the request this cycle
- mem_rdata  in  8  read data, valid exactly one cycle after the grant cycle
- out_data  out  8  column byte; bit k = pixel at row page*8+k (LSB = top)
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready
- busy  out  1  high from the start pulse until frame_done
- frame_done  out  1  one-cycle pulse after the 256th transfer

Behaviour:
- Reset (rst_n low at a clk edge) has priority over everything, including mid-frame:
  - state=IDLE
  - mem_req=0, mem_addr=0
  - out_valid=0, out_data=0
  - busy=0, frame_done=0
  - page, xb, row and col counters = 0
  - 8-byte block buffer contents are don't-care
- States:
  - IDLE: start -> REQ with page=0, xb=0, row=0. busy goes high on the next cycle.
  - REQ: mem_req=1, mem_addr=FB_BASE + (page*8+row)*8 + xb. Addr and req are stable until mem_gnt. On mem_gnt -> CAP.
  - CAP: mem_req=0. Store mem_rdata into block[row]. If row==7 -> EMIT with col=0; else row++ and -> REQ.
  - EMIT: out_valid=1, out_data bit k = block[k][7-col]. On transfer:
    - if col<7: col++.
    - else if xb<7: xb++, row=0, -> REQ.
    - else if page<3: page++, xb=0, row=0, -> REQ.
    - else -> IDLE, frame_done pulses, busy falls in the same cycle.
- Only one outstanding read at a time, so a byte costs at least 2 cycles.
- Output order: page 0..3, then x 0..63 within each page.
- out_data and out_valid are registered and hold stable while out_valid && !out_ready.
- out_valid is never deasserted without a transfer.
- start while busy is ignored. A start in the same cycle as frame_done is also ignored.
- mem_gnt is ignored outside REQ. mem_rdata is sampled only in CAP.
- Counter wrap: all counters are 3-bit (page 2-bit). Transitions are explicit; there is no natural wrap-around.
- Best-case frame latency: 256*(8*2/8 + 1) = 768 cycles plus the initial cycle.

Optional Feature:
- Macro: FB_SCANNER_FLIP_EN (display mounted rotated 180 degrees).
- Defined:
  - page order is 3..0, x order is 63..0.
  - column byte bit k = pixel at row page*8+7-k.
  - Output byte i equals the bit-reversed unflipped byte 255-i.
- Undefined: the order described in Behaviour.
- Memory access order may change under the macro; only the output stream is specified.

Test Plan:
- Zero framebuffer, start, out_ready=1, mem_gnt=1 -> 256 bytes of 0x00, frame_done pulses once, busy low afterwards, mem_addr covers exactly 0x100-0x1FF.
- 0x100=0x80, all other bytes 0 -> byte 0 = 0x01, bytes 1-255 = 0x00. Then 0x1FF=0x01 only -> byte 255 = 0x80. With FB_SCANNER_FLIP_EN: byte 0 = 0x01 for the 0x1FF case.
- 0x108=0xFF (row 1, xb 0) -> bytes 0-7 = 0x02, others 0. Glyph "1" at 0x138-0x158 (0x20,0x60,0x20,0x20,0xE0 per row... as stored) -> page 0/1 columns 0-3 match the hand-transposed values.
- Backpressure: drop out_ready for 5 cycles while valid -> out_data and out_valid unchanged. Hold mem_gnt low for 3 cycles -> mem_req and mem_addr stable, no state advance.
- Pulse start at cycle 10 mid-frame -> ignored, byte count stays 256. rst_n low for 1 cycle mid-EMIT -> all outputs 0 next cycle, and a fresh start yields a full correct 256-byte frame.
